// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker that refills the TLB on a miss or reports a page fault.
// Walks one 18-bit bus read per level; leaf PTE goes to the TLB fill port.
module tlb_refill_walker #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [7:0]  FAULT_USER     = 8'h82,
    parameter logic [7:0]  FAULT_KERN     = 8'h83
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [17:0] ptbr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic [31:0] req_pid,
    input  logic        req_kmode,
    input  logic        abort,
    output logic        mem_req,
    output logic [17:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        tlb_we,
    output logic [31:0] tlb_addr,
    output logic [31:0] tlb_pid,
    output logic [31:0] tlb_write_data,
    output logic        resp_valid,
    output logic [7:0]  resp_exc
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StL1,
        StL2,
        StFill,
        StFault,
        StDrain
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     vaddr_q;
    logic [31:0]     pid_q;
    logic            kmode_q;
    logic [5:0]      ptbr_q;
    logic [5:0]      pte1_q;
    logic            mem_req_q;
    logic [17:0]     mem_addr_q;
    logic            tlb_we_q;
    logic [31:0]     tlb_addr_q;
    logic [31:0]     tlb_pid_q;
    logic [31:0]     tlb_wdata_q;
    logic            resp_valid_q;
    logic [7:0]      resp_exc_q;

    logic [7:0] fault_code;
    logic       abort_en;
    logic       unused_bits;

    assign fault_code  = kmode_q ? FAULT_KERN : FAULT_USER;
    assign abort_en    = abort & clk_en;
    assign unused_bits = ^{ptbr[11:0], mem_rdata[31:27], ptbr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            vaddr_q      <= '0;
            pid_q        <= '0;
            kmode_q      <= 1'b0;
            ptbr_q       <= '0;
            pte1_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            tlb_we_q     <= 1'b0;
            tlb_addr_q   <= '0;
            tlb_pid_q    <= '0;
            tlb_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= '0;
        end else if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    resp_valid_q <= 1'b0;
                    if (!abort && req_valid) begin
                        vaddr_q    <= req_vaddr;
                        pid_q      <= req_pid;
                        kmode_q    <= req_kmode;
                        ptbr_q     <= ptbr[17:12];
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {ptbr[17:12], req_vaddr[31:22], 2'b00};
                        cnt_q      <= '0;
                        state_q    <= StL1;
                    end
                end

                StL1, StL2: begin
                    if (abort) begin
                        // Only an unanswered request must be drained off the bus.
                        cnt_q     <= '0;
                        mem_req_q <= 1'b0;
                        state_q   <= (mem_req_q && !mem_rvalid) ? StDrain : StIdle;
                    end else if (mem_req_q && mem_rvalid) begin
                        cnt_q     <= '0;
                        mem_req_q <= 1'b0;
                        if (!mem_rdata[5]) begin
                            resp_valid_q <= 1'b1;
                            resp_exc_q   <= fault_code;
                            state_q      <= StFault;
                        end else if (state_q == StL1) begin
                            pte1_q  <= mem_rdata[17:12];
                            state_q <= StL2;
                        end else begin
                            tlb_we_q    <= 1'b1;
                            tlb_addr_q  <= vaddr_q;
                            tlb_pid_q   <= pid_q;
                            tlb_wdata_q <= {5'b0, mem_rdata[26:0]};
                            state_q     <= StFill;
                        end
                    end else if (cnt_q == CntMax) begin
                        cnt_q        <= '0;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_exc_q   <= fault_code;
                        state_q      <= StFault;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        // L2 request goes out one cycle after the L1 response dropped mem_req.
                        if (!mem_req_q) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {pte1_q, vaddr_q[21:12], 2'b00};
                        end
                    end
                end

                StFill: begin
                    tlb_we_q <= 1'b0;
                    state_q  <= StIdle;
                    if (!abort) begin
                        resp_valid_q <= 1'b1;
                        resp_exc_q   <= 8'h00;
                    end
                end

                StFault: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end

                StDrain: begin
                    if (mem_rvalid || cnt_q == CntMax) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    // A flush in the pulse cycle cancels the pulse itself.
    assign tlb_we         = tlb_we_q & ~abort_en;
    assign resp_valid     = resp_valid_q & ~abort_en;
    assign req_ready      = (state_q == StIdle);
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign tlb_addr       = tlb_addr_q;
    assign tlb_pid        = tlb_pid_q;
    assign tlb_write_data = tlb_wdata_q;
    assign resp_exc       = resp_exc_q;

endmodule
